// File: rtl/mdu_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer.
// Op encodings, FSM state codes and special-case results.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL   = 3'b000;
    localparam logic [2:0] MDU_MULHU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b100;
    localparam logic [2:0] MDU_DIVU  = 3'b101;
    localparam logic [2:0] MDU_REM   = 3'b110;
    localparam logic [2:0] MDU_REMU  = 3'b111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NEG_A = 3'd1;
    localparam logic [2:0] S_NEG_B = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_NEG_R = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [4:0]  ITER_LAST = 5'd31;
    localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q     = 32'h8000_0000;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_special_det.sv
// Detects requests that finish without iterating, and the
// operand signs that steer the pre-negation states.
module mdu_special_det
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        special,
    output logic [31:0] spec_res,
    output logic        sign_a,
    output logic        sign_b
);

    logic rsvd;
    logic div0;
    logic ovf;
    logic sgn;

    always_comb begin
        sgn    = is_signed_op(op);
        rsvd   = (op == 3'b010) || (op == 3'b011);
        div0   = op[2] && (src2 == 32'd0);
        ovf    = sgn && (src1 == OVF_Q) && (src2 == 32'hFFFF_FFFF);
        sign_a = sgn && src1[31];
        sign_b = sgn && src2[31];

        special  = rsvd | div0 | ovf;
        spec_res = 32'd0;
        // REM/REMU share op[1]; they return the dividend or zero
        unique case (1'b1)
            rsvd:    spec_res = 32'd0;
            div0:    spec_res = op[1] ? src1 : DIV0_Q;
            ovf:     spec_res = op[1] ? 32'd0 : OVF_Q;
            default: spec_res = 32'd0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative shift-add multiplier / restoring divider that borrows
// the execute stage's shared adder through the add_* ports.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [XLEN-1:0] add_x,
    output logic [XLEN-1:0] add_y,
    output logic            add_afn,
    input  logic [XLEN-1:0] add_s,
    input  logic            add_cf
);

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    logic [4:0]  cnt;
    logic        negq;
    logic        negr;
    logic        valid_q;

    logic        special;
    logic [31:0] spec_res;
    logic        sign_a;
    logic        sign_b;

    logic        is_div;
    logic        sel_hi;
    logic        neg_flag;
    logic        need_neg;
    logic        ok;
    logic [31:0] t;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic [31:0] sel_n;

    mdu_special_det u_det (
        .op       (req_op),
        .src1     (req_src1),
        .src2     (req_src2),
        .special  (special),
        .spec_res (spec_res),
        .sign_a   (sign_a),
        .sign_b   (sign_b)
    );

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = valid_q;
    assign resp_data  = res;

    // For divides hi holds the remainder R and lo the quotient Q
    always_comb begin
        is_div   = op_q[2];
        sel_hi   = op_q[2] ? op_q[1] : op_q[0];
        t        = {hi[30:0], lo[31]};
        ok       = hi[31] | add_cf;
        hi_n     = is_div ? (ok ? add_s : t) : {add_cf, add_s[31:1]};
        lo_n     = is_div ? {lo[30:0], ok} : {add_s[0], lo[31:1]};
        sel_n    = sel_hi ? hi_n : lo_n;
        neg_flag = 1'b0;
        if (op_q == MDU_DIV) neg_flag = negq;
        if (op_q == MDU_REM) neg_flag = negr;
        need_neg = neg_flag && (sel_n != 32'd0);
    end

    always_comb begin
        add_x   = 32'd0;
        add_y   = 32'd0;
        add_afn = 1'b0;
        unique case (state)
            S_NEG_A: begin
                add_y   = a;
                add_afn = 1'b1;
            end
            S_NEG_B: begin
                add_y   = b;
                add_afn = 1'b1;
            end
            S_ITER: begin
                if (is_div) begin
                    add_x   = t;
                    add_y   = b;
                    add_afn = 1'b1;
                end else begin
                    add_x = hi;
                    add_y = lo[0] ? a : 32'd0;
                end
            end
            S_NEG_R: begin
                add_y   = sel_hi ? hi : lo;
                add_afn = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= 3'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            res     <= 32'd0;
            cnt     <= 5'd0;
            negq    <= 1'b0;
            negr    <= 1'b0;
            valid_q <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a    <= req_src1;
                        b    <= req_src2;
                        hi   <= 32'd0;
                        lo   <= req_op[2] ? req_src1 : req_src2;
                        cnt  <= 5'd0;
                        negq <= sign_a ^ sign_b;
                        negr <= sign_a;
                        if (special) begin
                            res     <= spec_res;
                            valid_q <= 1'b1;
                            state   <= S_DONE;
                        end else if (sign_a) begin
                            state <= S_NEG_A;
                        end else if (sign_b) begin
                            state <= S_NEG_B;
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                // Only signed divides reach here, so lo is the dividend
                S_NEG_A: begin
                    a     <= add_s;
                    lo    <= add_s;
                    state <= b[31] ? S_NEG_B : S_ITER;
                end
                S_NEG_B: begin
                    b     <= add_s;
                    state <= S_ITER;
                end
                S_ITER: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == ITER_LAST) begin
                        if (need_neg) begin
                            state <= S_NEG_R;
                        end else begin
                            res     <= sel_n;
                            valid_q <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_NEG_R: begin
                    res     <= add_s;
                    valid_q <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq with an external adder model
// and a plain-arithmetic reference for results and latency.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_afn;
    logic [31:0] add_s;
    logic        add_cf;
    logic [32:0] add_sum;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_afn    (add_afn),
        .add_s      (add_s),
        .add_cf     (add_cf)
    );

    assign add_sum = {1'b0, add_x} + {1'b0, add_y ^ {32{add_afn}}}
                   + {32'd0, add_afn};
    assign add_s   = add_sum[31:0];
    assign add_cf  = add_sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_model(
        input  logic [2:0]  op,
        input  logic [31:0] x,
        input  logic [31:0] y,
        output logic [31:0] r,
        output int          lat
    );
        logic [63:0] p;
        logic sgn, sa, sb, ovf, dz, special, neg;
        p   = {32'd0, x} * {32'd0, y};
        sgn = (op == MDU_DIV) || (op == MDU_REM);
        sa  = sgn && x[31];
        sb  = sgn && y[31];
        ovf = sgn && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        dz  = op[2] && (y == 32'd0);
        case (op)
            MDU_MUL:   r = p[31:0];
            MDU_MULHU: r = p[63:32];
            MDU_DIV:   r = dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                           : 32'($signed(x) / $signed(y));
            MDU_DIVU:  r = dz ? 32'hFFFF_FFFF : x / y;
            MDU_REM:   r = dz ? x : ovf ? 32'd0
                           : 32'($signed(x) % $signed(y));
            MDU_REMU:  r = dz ? x : x % y;
            default:   r = 32'd0;
        endcase
        special = (op == 3'b010) || (op == 3'b011) || dz || ovf;
        neg = 1'b0;
        if (op == MDU_DIV) neg = sa ^ sb;
        if (op == MDU_REM) neg = sa;
        if (special) lat = 1;
        else lat = 33 + int'(sa) + int'(sb) + int'(neg && (r != 32'd0));
    endfunction

    // Issues one request, returns the response and cycles to resp_valid.
    task automatic do_op(
        input  logic [2:0]  op,
        input  logic [31:0] x,
        input  logic [31:0] y,
        input  bit          consume,
        output logic [31:0] d,
        output int          lat,
        output bit          to
    );
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = x;
        req_src2  = y;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_src1  = $urandom;
        req_src2  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = !resp_valid;
        d  = resp_data;
        if (consume) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h ready=%b want 0/0/1",
                     resp_valid, resp_data, req_ready);
        end
        checks++;
        if (add_x !== 32'd0 || add_y !== 32'd0 || add_afn !== 1'b0) begin
            errors++;
            $display("FAIL reset_adder: x=%h y=%h afn=%b want zeros",
                     add_x, add_y, add_afn);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10];
        logic [31:0] xs  [10];
        logic [31:0] ys  [10];
        logic [31:0] want [10];
        int          wlat [10];
        logic [31:0] d;
        int lat;
        bit to;
        ops = '{MDU_MULHU, MDU_MUL, MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM,
                MDU_DIV, MDU_REMU, MDU_DIVU, MDU_DIVU};
        xs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5,
                32'd5, 32'hFFFF_FFFF};
        ys  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd7, 32'd7,
                32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
        want = '{32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFF2,
                 32'hFFFF_FFFE, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF};
        wlat = '{33, 33, 33, 33, 35, 35, 1, 1, 1, 33};
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], xs[i], ys[i], 1'b1, d, lat, to);
            checks++;
            if (to || d !== want[i] || lat != wlat[i]) begin
                errors++;
                $display("FAIL directed_%0d: data=%h lat=%0d to=%b want %h lat %0d",
                         i, d, lat, to, want[i], wlat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4];
        logic [31:0] x, y, d, want;
        logic [2:0]  op;
        int lat, wlat;
        bit to;
        corner = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            y  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) y = -y;
            ref_model(op, x, y, want, wlat);
            do_op(op, x, y, 1'b1, d, lat, to);
            checks++;
            if (to || d !== want || lat != wlat) begin
                errors++;
                $display("FAIL random_%0d op=%0d %h,%h: data=%h lat=%0d want %h lat %0d",
                         i, op, x, y, d, lat, want, wlat);
            end
        end
    endtask

    task automatic test_div_afn();
        int bad;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MDU_DIVU;
        req_src1  = 32'hFFFF_FFFF;
        req_src2  = 32'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (add_afn !== 1'b1 || resp_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_iter_afn: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_iter_result: valid=%b data=%h want 1/ffffffff",
                     resp_valid, resp_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int lat, bad;
        bit to;
        resp_ready = 1'b0;
        do_op(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, d, lat, to);
        checks++;
        if (to || d !== 32'h0B00_EA4E) begin
            errors++;
            $display("FAIL hold_result: data=%h to=%b want 0b00ea4e", d, to);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_data !== 32'h0B00_EA4E || req_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ready=%b valid=%b want 1/0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int lat, bad;
        bit to;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MDU_DIVU;
        req_src1  = 32'd1000;
        req_src2  = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_iter: valid=%b ready=%b want 0/1",
                     resp_valid, req_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_quiet: %0d cycles busy/valid, want 0", bad);
        end
        resp_ready = 1'b0;
        do_op(MDU_REMU, 32'd9, 32'd0, 1'b0, d, lat, to);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        resp_ready = 1'b1;
        checks++;
        if (to || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: to=%b valid=%b ready=%b want 0/0/1",
                     to, resp_valid, req_ready);
        end
        do_op(MDU_DIVU, 32'd1000, 32'd3, 1'b1, d, lat, to);
        checks++;
        if (to || d !== 32'd333 || lat != 33) begin
            errors++;
            $display("FAIL flush_after: data=%0d lat=%0d want 333 lat 33", d, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        bit to;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MDU_MUL;
        req_src1  = 32'hDEAD_BEEF;
        req_src2  = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0 || add_x !== 32'd0
            || add_y !== 32'd0 || add_afn !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h x=%h y=%h afn=%b want zeros",
                     resp_valid, resp_data, add_x, add_y, add_afn);
        end
        rst_n = 1'b1;
        do_op(MDU_REM, 32'd7, 32'hFFFF_FFFD, 1'b1, d, lat, to);
        checks++;
        if (to || d !== 32'd1 || lat != 34) begin
            errors++;
            $display("FAIL reset_after: data=%h lat=%0d want 1 lat 34", d, lat);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_src1   = 32'd0;
        req_src2   = 32'd0;
        resp_ready = 1'b1;
        test_reset();
        test_directed();
        test_div_afn();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the NPC execute stage.
- Owns no adder. It drives the shared 32-bit add/sub datapath through the `add_*` ports, which implement S = x + (y ^ {32{AFN}}) + AFN, with CF as carry-out.
- Implements MUL, MULHU, DIV, DIVU, REM and REMU using iterative shift-add and restoring division.
- Uses a valid/ready request interface and a valid/ready response interface toward the pipeline.

Parameters:
- XLEN, 32, operand width. Only 32 is supported because it must match the shared adder.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort in-flight op; the result is dropped
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  3  000 MUL, 001 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 010/011 reserved
- req_src1  in  32  multiplicand / dividend
- req_src2  in  32  multiplier / divisor
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- add_x  out  32  adder operand x
- add_y  out  32  adder operand y
- add_afn  out  1  adder mode: 0 add, 1 subtract
- add_s  in  32  adder sum
- add_cf  in  1  adder carry-out; on subtract, 1 means no borrow

Behaviour:
- Reset state:
  - State is IDLE.
  - resp_valid=0, resp_data=0, cnt=0, all internal registers 0.
  - add_x=0, add_y=0, add_afn=0 whenever no adder op is in progress.
- States: IDLE, NEG_A, NEG_B, ITER, NEG_R, DONE.
- IDLE, on accept (req_valid && req_ready), latch op and operands, then take the first matching branch:
  - Reserved op: go to DONE with result 0.
  - DIV/DIVU with src2==0: go to DONE. DIV/DIVU result is 0xFFFFFFFF; REM/REMU result is src1.
  - DIV/REM with src1==0x80000000 and src2==0xFFFFFFFF: go to DONE. DIV result is 0x80000000; REM result is 0.
  - Signed op with src1<0: go to NEG_A.
  - Else signed op with src2<0: go to NEG_B.
  - Else: go to ITER with cnt=0.
- NEG_A: drive add_x=0, add_y=A, afn=1; A<=add_s. Next state is NEG_B if B<0, else ITER.
- NEG_B: same negation for B, then go to ITER.
- Record sign flags at accept:
  - negq = sA ^ sB
  - negr = sA
- ITER, multiply:
  - P={hi,lo} with hi=0 and lo=src2 at start.
  - Drive add_x=hi, add_y = lo[0] ? A : 0, afn=0.
  - Update hi<={add_cf, add_s[31:1]} and lo<={add_s[0], lo[31:1]}.
- ITER, divide:
  - Remainder R=0 at start; quotient register Q=A.
  - Let t={R[30:0],Q[31]}. Drive add_x=t, add_y=B, afn=1.
  - ok = R[31] | add_cf.
  - R <= ok ? add_s : t.
  - Q <= {Q[30:0], ok}.
- ITER count:
  - Exactly 32 iterations, cnt 0..31.
  - At cnt==31, go to NEG_R if the signed result needs negation (selected result nonzero sign-flagged), else DONE.
- NEG_R: drive add_x=0, add_y=selected result, afn=1; store add_s, then go to DONE.
- Result selection:
  - MUL returns lo; MULHU returns hi.
  - DIV/DIVU return Q; REM/REMU return R.
- DONE and response:
  - resp_valid=1 with resp_data stable.
  - Hold until resp_ready. On the handshake cycle, go to IDLE and clear resp_valid.
  - req_ready is 0 in DONE, so there is no back-to-back overlap.
- Latency, with accept at cycle 0:
  - Unsigned op: resp_valid at cycle 33.
  - Signed op: plus 1 per negative operand, plus 1 for NEG_R. Maximum is 36.
  - Special cases: cycle 1.
- flush:
  - From any state, go to IDLE next cycle with resp_valid=0.
  - flush has priority over resp handshake and request accept.
  - Requests are not accepted in a cycle with flush=1.
- rst_n low mid-operation: same as reset; the operation is silently lost.
- Adder ports are combinational from state and registers only, never from req_* inputs.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (MDU_MUL … MDU_REMU)
  - state enum encoding
  - ITER_LAST=31
  - special-result constants DIV0_Q=32'hFFFFFFFF and OVF_Q=32'h80000000
- Sub-module mdu_special_det: combinational detect of divide-by-zero, signed overflow, reserved op and operand signs. It is instantiated once in mdu_seq.
- The adder is instantiated outside and connected by the parent.

Test Plan:
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> resp_data 0xFFFFFFFE at cycle 33. The same operands with MUL -> 0x00000001.
- DIVU 100/7 -> 14 at cycle 33; REMU 100/7 -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14) at cycle 35; REM -100/7 -> 0xFFFFFFFE (-2).
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REMU 5/0 -> 5 and DIVU 5/0 -> 0xFFFFFFFF, both at cycle 1.
- DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF, exercising the R[31] shifted-out path. Also check that add_afn=1 throughout ITER.
- Hold resp_ready=0 for 10 cycles after DONE -> resp_valid and resp_data stable, req_ready=0. Then pulse resp_ready -> next-cycle req_ready=1.
- Assert flush at ITER cnt=10 -> IDLE next cycle with no resp_valid. rst_n=0 at cnt=20 -> all outputs 0 next cycle, and a new request is accepted afterward.
